vga_sync: RTL and testbench

- VGA timing generator for 640x480@60Hz. The mode is selected by the `_VGA_640_480` macro from the shared `vga.vh` header.
- Runs on the pixel clock and produces horizontal and vertical sync, a video-on (active-area) flag, and the current pixel x/y address.
- Sits between the pixel clock source and the frame buffer / pixel generator. Optionally drives control pins of an external ADV7123 video DAC.

---
 rtl/vga_sync_pkg.sv | 38 +++
 rtl/vga_sync_timing_counter.sv | 30 +++
 rtl/vga_sync.sv | 99 +++++++++
 tb/tb_vga_sync.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/vga_sync_pkg.sv
// Shared VGA timing constants and decode helpers.
// The video mode is chosen by a mode macro such as _VGA_640_480 (640x480@60Hz);
// 640x480 timing is used when no mode macro is supplied.
package vga_sync_pkg;

`ifdef _VGA_640_480
  localparam int HVA = 640;   // horizontal visible pixels
  localparam int HFP = 16;    // horizontal front porch
  localparam int HSP = 96;    // horizontal sync pulse
  localparam int HBP = 48;    // horizontal back porch
  localparam int VVA = 480;   // vertical visible lines
  localparam int VFP = 10;    // vertical front porch
  localparam int VSP = 2;     // vertical sync pulse
  localparam int VBP = 33;    // vertical back porch
  localparam logic HSYNC_POL = 1'b0;
  localparam logic VSYNC_POL = 1'b0;
`else
  localparam int HVA = 640;   // horizontal visible pixels
  localparam int HFP = 16;    // horizontal front porch
  localparam int HSP = 96;    // horizontal sync pulse
  localparam int HBP = 48;    // horizontal back porch
  localparam int VVA = 480;   // vertical visible lines
  localparam int VFP = 10;    // vertical front porch
  localparam int VSP = 2;     // vertical sync pulse
  localparam int VBP = 33;    // vertical back porch
  localparam logic HSYNC_POL = 1'b0;
  localparam logic VSYNC_POL = 1'b0;
`endif

  localparam int HT = HVA + HFP + HSP + HBP;
  localparam int VT = VVA + VFP + VSP + VBP;

  // True when pos lies in the half-open window [lo, lo+len).
  function automatic logic in_window(input int pos, input int lo, input int len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/vga_sync_timing_counter.sv
// Mod-N counter with an enable and a terminal-count flag; used once for
// pixels within a line and once for lines within a frame.
module vga_timing_counter #(
  parameter int N = 800,
  parameter int W = $clog2(N)
) (
  input  logic         vga_clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // Terminal count is decoded straight from the register so it lines up with cnt.
  assign tc = (cnt == W'(N - 1));

  // Count up while enabled, wrapping from N-1 back to zero.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (tc) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_sync.sv
// VGA sync generator: horizontal/vertical counters plus combinational
// decode of sync pulses, active-area flag and pixel address.
// Optional macro ADV7123_EN adds control pins for an ADV7123 video DAC.
module vga_sync
  import vga_sync_pkg::*;
#(
  parameter int   P_HVA       = HVA,
  parameter int   P_HFP       = HFP,
  parameter int   P_HSP       = HSP,
  parameter int   P_HBP       = HBP,
  parameter int   P_VVA       = VVA,
  parameter int   P_VFP       = VFP,
  parameter int   P_VSP       = VSP,
  parameter int   P_VBP       = VBP,
  parameter logic P_HSYNC_POL = HSYNC_POL,
  parameter logic P_VSYNC_POL = VSYNC_POL,
  parameter int   HADDRW      = $clog2(P_HVA),
  parameter int   VADDRW      = $clog2(P_VVA)
) (
  input  logic              vga_clk,
  input  logic              rst,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vga_video_on,
  output logic [HADDRW-1:0] vga_h_addr,
  output logic [VADDRW-1:0] vga_v_addr
`ifdef ADV7123_EN
  ,
  output logic              adv7123_vga_blank,
  output logic              adv7123_vga_sync,
  output logic              adv7123_vga_clk
`endif
);

  localparam int P_HT = P_HVA + P_HFP + P_HSP + P_HBP;
  localparam int P_VT = P_VVA + P_VFP + P_VSP + P_VBP;
  localparam int HCW  = $clog2(P_HT);
  localparam int VCW  = $clog2(P_VT);

  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic           h_tc;
  logic           frame_end_unused;

  vga_timing_counter #(.N(P_HT), .W(HCW)) u_h_cnt (
    .vga_clk (vga_clk),
    .rst     (rst),
    .en      (1'b1),
    .cnt     (h_cnt),
    .tc      (h_tc)
  );

  // Lines advance only on the last pixel of each line.
  vga_timing_counter #(.N(P_VT), .W(VCW)) u_v_cnt (
    .vga_clk (vga_clk),
    .rst     (rst),
    .en      (h_tc),
    .cnt     (v_cnt),
    .tc      (frame_end_unused)
  );

  // Decode visible area, sync windows and addresses with zero latency to the counters.
  always_comb begin
    logic h_vis;
    logic v_vis;
    h_vis        = (int'(h_cnt) < P_HVA);
    v_vis        = (int'(v_cnt) < P_VVA);
    vga_video_on = h_vis && v_vis;
    if (in_window(int'(h_cnt), P_HVA + P_HFP, P_HSP)) begin
      vga_hsync = P_HSYNC_POL;
    end else begin
      vga_hsync = ~P_HSYNC_POL;
    end
    if (in_window(int'(v_cnt), P_VVA + P_VFP, P_VSP)) begin
      vga_vsync = P_VSYNC_POL;
    end else begin
      vga_vsync = ~P_VSYNC_POL;
    end
    if (h_vis) begin
      vga_h_addr = h_cnt[HADDRW-1:0];
    end else begin
      vga_h_addr = '0;
    end
    if (v_vis) begin
      vga_v_addr = v_cnt[VADDRW-1:0];
    end else begin
      vga_v_addr = '0;
    end
  end

`ifdef ADV7123_EN
  // DAC blank_n follows the active area; sync-on-green is unused; the DAC clock
  // is inverted so it samples in the middle of each pixel.
  assign adv7123_vga_blank = vga_video_on;
  assign adv7123_vga_sync  = 1'b0;
  assign adv7123_vga_clk   = ~vga_clk;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync. u_dut uses the default 640x480 timing; u_small
// keeps the horizontal timing but shortens the frame (4 visible lines, porches
// of 2, sync of 2 lines, 10 lines total) so vertical behaviour fits in a short run.
module tb_vga_sync;

  logic       vga_clk = 1'b0;
  logic       rst     = 1'b1;
  logic       hsync, vsync, video_on;
  logic [9:0] h_addr;
  logic [8:0] v_addr;
  logic       s_hsync, s_vsync, s_video_on;
  logic [9:0] s_h_addr;
  logic [1:0] s_v_addr;
`ifdef ADV7123_EN
  logic       dac_blank, dac_sync, dac_clk;
  logic       s_dac_blank, s_dac_sync, s_dac_clk;
`endif

  int total = 0;
  int bad   = 0;

  always #20 vga_clk = ~vga_clk;

  vga_sync u_dut (
    .vga_clk      (vga_clk),
    .rst          (rst),
    .vga_hsync    (hsync),
    .vga_vsync    (vsync),
    .vga_video_on (video_on),
    .vga_h_addr   (h_addr),
    .vga_v_addr   (v_addr)
`ifdef ADV7123_EN
    ,
    .adv7123_vga_blank (dac_blank),
    .adv7123_vga_sync  (dac_sync),
    .adv7123_vga_clk   (dac_clk)
`endif
  );

  vga_sync #(.P_VVA(4), .P_VFP(2), .P_VSP(2), .P_VBP(2)) u_small (
    .vga_clk      (vga_clk),
    .rst          (rst),
    .vga_hsync    (s_hsync),
    .vga_vsync    (s_vsync),
    .vga_video_on (s_video_on),
    .vga_h_addr   (s_h_addr),
    .vga_v_addr   (s_v_addr)
`ifdef ADV7123_EN
    ,
    .adv7123_vga_blank (s_dac_blank),
    .adv7123_vga_sync  (s_dac_sync),
    .adv7123_vga_clk   (s_dac_clk)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_h_addr"}, 32'(h_addr), 32'd0);
    chk({tag, "_v_addr"}, 32'(v_addr), 32'd0);
    chk({tag, "_video_on"}, 32'(video_on), 32'd1);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_s_v_addr"}, 32'(s_v_addr), 32'd0);
    chk({tag, "_s_vsync"}, 32'(s_vsync), 32'd1);
  endtask

  initial begin
    int von_cnt;
    int hs_cnt;
    int vs_cnt;
    int line;

    // Reset held for 100 ns, then checked between edges.
    #110;
    chk_reset_vals("reset");
    @(posedge vga_clk);
    #5 rst = 1'b0;
    chk_reset_vals("release");

    // Pixel stepping and the visible/blank boundary on line 0.
    step(1);   chk("h_step1", 32'(h_addr), 32'd1);
    step(1);   chk("h_step2", 32'(h_addr), 32'd2);
    step(637); chk("h_639", 32'(h_addr), 32'd639);
    chk("von_639", 32'(video_on), 32'd1);
`ifdef ADV7123_EN
    chk("dac_blank_vis", 32'(dac_blank), 32'd1);
    chk("dac_sync", 32'(dac_sync), 32'd0);
    chk("dac_clk_hi", 32'(dac_clk), 32'd0);
`endif
    step(1);   chk("h_640", 32'(h_addr), 32'd0);
    chk("von_640", 32'(video_on), 32'd0);
`ifdef ADV7123_EN
    chk("dac_blank_blank", 32'(dac_blank), 32'd0);
    #20;
    chk("dac_clk_lo", 32'(dac_clk), 32'd1);
    @(posedge vga_clk); #1;
    step(14);
`else
    step(15);
`endif
    chk("hs_655", 32'(hsync), 32'd1);
    step(1);   chk("hs_656", 32'(hsync), 32'd0);
    step(95);  chk("hs_751", 32'(hsync), 32'd0);
    step(1);   chk("hs_752", 32'(hsync), 32'd1);
    step(47);  chk("v_line0_end", 32'(v_addr), 32'd0);
    step(1);   chk("v_line1", 32'(v_addr), 32'd1);
    chk("h_wrap", 32'(h_addr), 32'd0);
    chk("von_line1", 32'(video_on), 32'd1);

    // Whole line 1: active width, sync width and period.
    von_cnt = 0;
    hs_cnt  = 0;
    for (int c = 0; c < 800; c++) begin
      if (video_on) von_cnt++;
      if (!hsync) hs_cnt++;
      step(1);
    end
    chk("line_von_clocks", 32'(von_cnt), 32'd640);
    chk("line_hs_clocks", 32'(hs_cnt), 32'd96);
    chk("line_period_v", 32'(v_addr), 32'd2);
    chk("line_period_h", 32'(h_addr), 32'd0);

    // One full short frame starting at line 2: addresses, vsync window, period.
    vs_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      line = (2 + i) % 10;
      chk($sformatf("s_vaddr_l%0d", line), 32'(s_v_addr), (line < 4) ? 32'(line) : 32'd0);
      chk($sformatf("s_von_l%0d", line), 32'(s_video_on), (line < 4) ? 32'd1 : 32'd0);
      chk($sformatf("s_vs_l%0d", line), 32'(s_vsync), (line == 6 || line == 7) ? 32'd0 : 32'd1);
      for (int c = 0; c < 800; c++) begin
        if (!s_vsync) vs_cnt++;
        step(1);
      end
    end
    chk("s_vs_clocks", 32'(vs_cnt), 32'd1600);
    chk("s_frame_wrap", 32'(s_v_addr), 32'd2);
    chk("main_v_addr12", 32'(v_addr), 32'd12);

    // Step into the sync region, then assert reset between clock edges.
    step(700);
    chk("pre_rst_hs", 32'(hsync), 32'd0);
    #10 rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    @(posedge vga_clk);
    #5 rst = 1'b0;
    chk("restart_h0", 32'(h_addr), 32'd0);
    step(3);
    chk("restart_h3", 32'(h_addr), 32'd3);
    chk("restart_v0", 32'(v_addr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
